// File: rtl/mem_bram_responder.sv
// Block-RAM backed responder for the mem_* request/response interface.
// Accepts one single-word read or write at a time, answers with a one-cycle
// mem_response pulse after a fixed latency, and waits for the initiator to
// drop its request before accepting the next one.
module mem_bram_responder #(
    parameter int MEM_WIDTH     = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [MEM_WIDTH-1:0]  mem_write_val,
    output logic [MEM_WIDTH-1:0]  mem_read_val,
    output logic                  mem_response,
    output logic                  mem_error,
    output logic                  busy
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [IDX_W-1:0]       addr_r;
    logic [MEM_WIDTH-1:0]   data_r;
    logic                   op_write_r;
    logic                   err_r;
    logic [MEM_WIDTH-1:0]   read_val_r;
    logic                   response_r;
    logic                   error_r;
    logic                   busy_r;

    logic [MEM_WIDTH-1:0]   ram_r [DEPTH];

    logic                   req_s;
    logic                   is_write_s;
    logic                   range_err_s;
    logic                   proto_err_s;
    logic                   acc_err_s;
    logic                   accept_s;
    logic [CNT_W-1:0]       lat_load_s;
    logic                   err_cur_s;
    logic                   op_write_cur_s;
    logic [IDX_W-1:0]       rd_idx_s;
    logic                   enter_resp_s;
    logic                   ram_we_s;

    // A request is live while either enable is high; a write is only a write
    // when read is not also asserted (both high is a protocol error).
    assign req_s       = mem_read_en | mem_write_en;
    assign is_write_s  = mem_write_en & ~mem_read_en;
    assign range_err_s = |mem_addr[ADDR_WIDTH-1:IDX_W];
    assign proto_err_s = mem_read_en & mem_write_en;
    assign acc_err_s   = range_err_s | proto_err_s;
    assign accept_s    = (state_r == ST_IDLE) && req_s;
    assign lat_load_s  = is_write_s ? WR_LOAD : RD_LOAD;

    // With a one-cycle latency RESP is entered straight from IDLE, before the
    // request has been latched, so the live inputs must be used in that case.
    assign err_cur_s      = (state_r == ST_IDLE) ? acc_err_s : err_r;
    assign op_write_cur_s = (state_r == ST_IDLE) ? is_write_s : op_write_r;
    assign rd_idx_s       = (state_r == ST_IDLE) ? mem_addr[IDX_W-1:0] : addr_r;
    assign enter_resp_s   = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
    assign ram_we_s       = (state_r == ST_RESP) && op_write_r && !err_r;

    // Next-state and latency counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (lat_load_s == CNT_ZERO) begin
                        state_nxt_s = ST_RESP;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_BUSY;
                        cnt_nxt_s   = lat_load_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_BUSY: begin
                if (!req_s) begin
                    // Initiator withdrew the request: abandon it silently.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_RESP;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            addr_r     <= {IDX_W{1'b0}};
            data_r     <= {MEM_WIDTH{1'b0}};
            op_write_r <= 1'b0;
            err_r      <= 1'b0;
            read_val_r <= {MEM_WIDTH{1'b0}};
            response_r <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            response_r <= (state_nxt_s == ST_RESP);
            error_r    <= (state_nxt_s == ST_RESP) && err_cur_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            if (accept_s) begin
                addr_r     <= mem_addr[IDX_W-1:0];
                data_r     <= mem_write_val;
                op_write_r <= is_write_s;
                err_r      <= acc_err_s;
            end
            if (enter_resp_s) begin
                if (err_cur_s) begin
                    read_val_r <= {MEM_WIDTH{1'b0}};
                end else if (!op_write_cur_s) begin
                    read_val_r <= ram_r[rd_idx_s];
                end else begin
                    read_val_r <= read_val_r;
                end
            end
        end
    end

    // RAM write commits on the edge that closes the response cycle.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[addr_r] <= data_r;
        end
    end

    assign mem_read_val = read_val_r;
    assign mem_response = response_r;
    assign mem_error    = error_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_mem_bram_responder.sv
// Self-checking bench for mem_bram_responder: scoreboard of expected
// responses, one task per scenario.
module tb_mem_bram_responder;

    localparam int MW = 32;
    localparam int AW = 32;
    localparam int DP = 256;
    localparam int RL = 4;
    localparam int WL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_addr;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [MW-1:0] mem_write_val;
    logic [MW-1:0] mem_read_val;
    logic          mem_response;
    logic          mem_error;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit            exp_err;
        bit            chk_data;
        logic [MW-1:0] exp_data;
        int            exp_lat;
    } sb_t;

    sb_t sb_q[$];

    mem_bram_responder #(
        .MEM_WIDTH    (MW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DP),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_write_val(mem_write_val),
        .mem_read_val (mem_read_val),
        .mem_response (mem_response),
        .mem_error    (mem_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Drive one request, wait for its response, then drop the enables.
    // lat counts falling edges after the accepting rising edge.
    task automatic do_req(input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [MW-1:0] d, output int lat, output logic err,
                          output logic [MW-1:0] val, output bit to);
        @(negedge clk);
        mem_addr      = a;
        mem_read_en   = r;
        mem_write_en  = w;
        mem_write_val = d;
        lat = 0;
        err = 1'b0;
        val = '0;
        to  = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (mem_response) begin
                lat = k;
                err = mem_error;
                val = mem_read_val;
                to  = 1'b0;
                break;
            end
        end
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_addr = '0; mem_read_en = 1'b0; mem_write_en = 1'b0; mem_write_val = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (mem_response !== 1'b0) begin n_fail++; $display("FAIL rst_response: got %b expected 0", mem_response); end
        n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b expected 0", mem_error); end
        n_checks++; if (mem_read_val !== 32'h0) begin n_fail++; $display("FAIL rst_read_val: got %h expected 0", mem_read_val); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic err; logic [MW-1:0] val; bit to; sb_t e;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{exp_err: 1'b0, chk_data: 1'b0, exp_data: 32'h0, exp_lat: WL});
            do_req(1'b0, 1'b1, AW'(i), MW'(i + 1), lat, err, val, to);
            e = sb_q.pop_front();
            n_checks++;
            if (to) begin n_fail++; $display("FAIL wr_timeout[%0d]: no response", i); end
            else if (lat !== e.exp_lat || err !== e.exp_err) begin
                n_fail++; $display("FAIL wr[%0d]: lat %0d err %b expected lat %0d err %b", i, lat, err, e.exp_lat, e.exp_err);
            end
        end
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{exp_err: 1'b0, chk_data: 1'b1, exp_data: MW'(i + 1), exp_lat: RL});
            do_req(1'b1, 1'b0, AW'(i), 32'h0, lat, err, val, to);
            e = sb_q.pop_front();
            n_checks++;
            if (to) begin n_fail++; $display("FAIL rd_timeout[%0d]: no response", i); end
            else if (lat !== e.exp_lat || err !== e.exp_err || val !== e.exp_data) begin
                n_fail++; $display("FAIL rd[%0d]: lat %0d err %b data %h expected lat %0d err %b data %h",
                                   i, lat, err, val, e.exp_lat, e.exp_err, e.exp_data);
            end
        end
    endtask

    task automatic test_held_read();
        int pulses = 0; bit busy_ok = 1'b1; logic [MW-1:0] val = '0;
        @(negedge clk);
        mem_addr = 32'd3; mem_read_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_response) begin pulses++; val = mem_read_val; end
            if (!busy) busy_ok = 1'b0;
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL held_pulses: got %0d expected 1", pulses); end
        n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL held_busy: busy dropped while request held"); end
        n_checks++; if (val !== 32'd4) begin n_fail++; $display("FAIL held_data: got %h expected 4", val); end
        mem_read_en = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_release: busy %b expected 0", busy); end
    endtask

    task automatic test_out_of_range();
        int lat; logic err; logic [MW-1:0] val; bit to; sb_t e;
        sb_q.push_back('{exp_err: 1'b1, chk_data: 1'b1, exp_data: 32'h0, exp_lat: WL});
        do_req(1'b0, 1'b1, 32'h100, 32'hDEAD, lat, err, val, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to) begin n_fail++; $display("FAIL oor_timeout: no response"); end
        else if (lat !== e.exp_lat || err !== e.exp_err || val !== e.exp_data) begin
            n_fail++; $display("FAIL oor_wr: lat %0d err %b data %h expected lat %0d err %b data %h",
                               lat, err, val, e.exp_lat, e.exp_err, e.exp_data);
        end
        sb_q.push_back('{exp_err: 1'b0, chk_data: 1'b1, exp_data: 32'd1, exp_lat: RL});
        do_req(1'b1, 1'b0, 32'h0, 32'h0, lat, err, val, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to || err !== e.exp_err || val !== e.exp_data) begin
            n_fail++; $display("FAIL oor_rd0: to %b err %b data %h expected data %h", to, err, val, e.exp_data);
        end
    endtask

    task automatic test_both_en();
        int lat; logic err; logic [MW-1:0] val; bit to; sb_t e;
        sb_q.push_back('{exp_err: 1'b1, chk_data: 1'b1, exp_data: 32'h0, exp_lat: 0});
        do_req(1'b1, 1'b1, 32'd5, 32'hBEEF, lat, err, val, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to || err !== e.exp_err || val !== e.exp_data) begin
            n_fail++; $display("FAIL both_en: to %b err %b data %h expected err 1 data 0", to, err, val);
        end
        sb_q.push_back('{exp_err: 1'b0, chk_data: 1'b1, exp_data: 32'd6, exp_lat: RL});
        do_req(1'b1, 1'b0, 32'd5, 32'h0, lat, err, val, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to || err !== e.exp_err || val !== e.exp_data) begin
            n_fail++; $display("FAIL both_en_rd5: to %b err %b data %h expected %h", to, err, val, e.exp_data);
        end
    endtask

    task automatic test_abort();
        int lat; logic err; logic [MW-1:0] val; bit to; sb_t e; int resp_cnt = 0;
        do_req(1'b0, 1'b1, 32'd9, 32'h99, lat, err, val, to);
        n_checks++; if (to || err !== 1'b0) begin n_fail++; $display("FAIL abort_setup: to %b err %b expected response", to, err); end
        @(negedge clk);
        mem_addr = 32'd9; mem_write_val = 32'h55; mem_write_en = 1'b1;
        @(negedge clk);
        if (mem_response) resp_cnt++;
        mem_write_en = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        for (int k = 0; k < 6; k++) begin
            if (mem_response) resp_cnt++;
            @(negedge clk);
        end
        n_checks++; if (resp_cnt !== 0) begin n_fail++; $display("FAIL abort_resp: got %0d responses expected 0", resp_cnt); end
        sb_q.push_back('{exp_err: 1'b0, chk_data: 1'b1, exp_data: 32'h99, exp_lat: RL});
        do_req(1'b1, 1'b0, 32'd9, 32'h0, lat, err, val, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to || val !== e.exp_data || lat !== e.exp_lat) begin
            n_fail++; $display("FAIL abort_rd9: to %b data %h lat %0d expected %h lat %0d", to, val, lat, e.exp_data, e.exp_lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic err; logic [MW-1:0] val; bit to; sb_t e;
        @(negedge clk);
        mem_addr = 32'd2; mem_write_val = 32'hAA; mem_write_en = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || mem_response !== 1'b0 || mem_error !== 1'b0 || mem_read_val !== 32'h0) begin
            n_fail++; $display("FAIL rmid_outputs: busy %b resp %b err %b data %h expected all 0",
                               busy, mem_response, mem_error, mem_read_val);
        end
        repeat (3) @(negedge clk);
        mem_write_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        sb_q.push_back('{exp_err: 1'b0, chk_data: 1'b1, exp_data: 32'd3, exp_lat: RL});
        do_req(1'b1, 1'b0, 32'd2, 32'h0, lat, err, val, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to || val !== e.exp_data || lat !== e.exp_lat || err !== e.exp_err) begin
            n_fail++; $display("FAIL rmid_rd2: to %b data %h lat %0d err %b expected %h lat %0d",
                               to, val, lat, err, e.exp_data, e.exp_lat);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held_read();
        test_out_of_range();
        test_both_en();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
